// File: rtl/src_wakeup_buffer.sv
// Operand wakeup buffer: holds entries until both source operands are resolved by write-back broadcasts.
// Optional macro SRC_WAKEUP_ALLOC_BYPASS_EN lets an allocating operand also catch same-cycle broadcasts.
`ifndef DATA_LEN
  `define DATA_LEN 32
`endif
`ifndef RRF_SEL
  `define RRF_SEL 6
`endif

module src_wakeup_buffer #(
  parameter int DATA_W = `DATA_LEN,
  parameter int TAG_W  = `RRF_SEL,
  parameter int DEPTH  = 4,
  parameter int NUM_WB = 5
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic                       alloc_valid_i,
  output logic                       alloc_ready_o,
  input  logic [DATA_W-1:0]          alloc_src1_i,
  input  logic [DATA_W-1:0]          alloc_src2_i,
  input  logic                       alloc_src1_ready_i,
  input  logic                       alloc_src2_ready_i,
  input  logic [TAG_W-1:0]           alloc_dst_i,
  input  logic [NUM_WB-1:0]          wb_valid_i,
  input  logic [NUM_WB*TAG_W-1:0]    wb_tag_i,
  input  logic [NUM_WB*DATA_W-1:0]   wb_data_i,
  output logic                       issue_valid_o,
  input  logic                       issue_ready_i,
  output logic [DATA_W-1:0]          issue_src1_o,
  output logic [DATA_W-1:0]          issue_src2_o,
  output logic [TAG_W-1:0]           issue_dst_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  dst;
    logic [DATA_W-1:0] src1;
    logic              rdy1;
    logic [DATA_W-1:0] src2;
    logic              rdy2;
  } entry_t;

  entry_t ent_q [DEPTH];
  entry_t ent_d [DEPTH];

  // Once a stalled entry is presented, its index is locked so a lower entry waking up cannot displace it.
  logic             hold_q;
  logic [IDX_W-1:0] held_idx_q;

  logic             cand_found;
  logic [IDX_W-1:0] cand_idx;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] issue_idx;
  logic             do_issue;
  logic             do_alloc;

  // Returns {hit, data}; scanning downwards lets the lowest matching channel win.
  function automatic logic [DATA_W:0] wakeup(
    input logic [TAG_W-1:0]         tag,
    input logic [NUM_WB-1:0]        v,
    input logic [NUM_WB*TAG_W-1:0]  t,
    input logic [NUM_WB*DATA_W-1:0] d
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int k = NUM_WB - 1; k >= 0; k--) begin
      if (v[k] && (t[k*TAG_W +: TAG_W] == tag)) r = {1'b1, d[k*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  // NOTE: every combinational output gets a default before any branch, otherwise a latch is inferred.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    free_found = 1'b0;
    free_idx   = '0;
    cnt        = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2) begin
        cand_found = 1'b1;
        cand_idx   = IDX_W'(i);
      end
      if (!ent_q[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      cnt = cnt + CNT_W'(ent_q[i].valid);
    end
  end

  assign count_o       = cnt;
  assign alloc_ready_o = (cnt < CNT_W'(DEPTH));
  assign issue_idx     = hold_q ? held_idx_q : cand_idx;
  assign issue_valid_o = hold_q | cand_found;
  assign issue_src1_o  = issue_valid_o ? ent_q[issue_idx].src1 : '0;
  assign issue_src2_o  = issue_valid_o ? ent_q[issue_idx].src2 : '0;
  assign issue_dst_o   = issue_valid_o ? ent_q[issue_idx].dst  : '0;

  assign do_issue = issue_valid_o & issue_ready_i & ~flush_i;
  assign do_alloc = alloc_valid_i & alloc_ready_o & ~flush_i & free_found;

  always_comb begin
    logic [DATA_W:0] w1;
    logic [DATA_W:0] w2;
    w1 = '0;
    w2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].valid && !ent_q[i].rdy1) begin
        w1 = wakeup(ent_q[i].src1[TAG_W-1:0], wb_valid_i, wb_tag_i, wb_data_i);
        if (w1[DATA_W]) begin
          ent_d[i].src1 = w1[DATA_W-1:0];
          ent_d[i].rdy1 = 1'b1;
        end
      end
      if (ent_q[i].valid && !ent_q[i].rdy2) begin
        w2 = wakeup(ent_q[i].src2[TAG_W-1:0], wb_valid_i, wb_tag_i, wb_data_i);
        if (w2[DATA_W]) begin
          ent_d[i].src2 = w2[DATA_W-1:0];
          ent_d[i].rdy2 = 1'b1;
        end
      end
    end

    if (do_issue) ent_d[issue_idx].valid = 1'b0;

    if (do_alloc) begin
      ent_d[free_idx].valid = 1'b1;
      ent_d[free_idx].dst   = alloc_dst_i;
      ent_d[free_idx].src1  = alloc_src1_i;
      ent_d[free_idx].rdy1  = alloc_src1_ready_i;
      ent_d[free_idx].src2  = alloc_src2_i;
      ent_d[free_idx].rdy2  = alloc_src2_ready_i;
`ifdef SRC_WAKEUP_ALLOC_BYPASS_EN
      if (!alloc_src1_ready_i) begin
        w1 = wakeup(alloc_src1_i[TAG_W-1:0], wb_valid_i, wb_tag_i, wb_data_i);
        if (w1[DATA_W]) begin
          ent_d[free_idx].src1 = w1[DATA_W-1:0];
          ent_d[free_idx].rdy1 = 1'b1;
        end
      end
      if (!alloc_src2_ready_i) begin
        w2 = wakeup(alloc_src2_i[TAG_W-1:0], wb_valid_i, wb_tag_i, wb_data_i);
        if (w2[DATA_W]) begin
          ent_d[free_idx].src2 = w2[DATA_W-1:0];
          ent_d[free_idx].rdy2 = 1'b1;
        end
      end
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      // NOTE: the entry array is fully cleared (not just valid) so idle outputs read back as zero.
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      hold_q     <= 1'b0;
      held_idx_q <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      hold_q     <= 1'b0;
      held_idx_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      hold_q     <= issue_valid_o & ~issue_ready_i;
      held_idx_q <= issue_idx;
    end
  end

endmodule

// File: tb/tb_src_wakeup_buffer.sv
// Scoreboard bench for src_wakeup_buffer: expected issues are queued at stimulus time and compared on handshake.
module tb_src_wakeup_buffer;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;
  localparam int DEPTH  = 4;
  localparam int NUM_WB = 5;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic                     clk = 1'b0;
  logic                     reset_i = 1'b1;
  logic                     flush_i = 1'b0;
  logic                     alloc_valid_i = 1'b0;
  logic                     alloc_ready_o;
  logic [DATA_W-1:0]        alloc_src1_i = '0;
  logic [DATA_W-1:0]        alloc_src2_i = '0;
  logic                     alloc_src1_ready_i = 1'b0;
  logic                     alloc_src2_ready_i = 1'b0;
  logic [TAG_W-1:0]         alloc_dst_i = '0;
  logic [NUM_WB-1:0]        wb_valid_i = '0;
  logic [NUM_WB*TAG_W-1:0]  wb_tag_i = '0;
  logic [NUM_WB*DATA_W-1:0] wb_data_i = '0;
  logic                     issue_valid_o;
  logic                     issue_ready_i = 1'b0;
  logic [DATA_W-1:0]        issue_src1_o;
  logic [DATA_W-1:0]        issue_src2_o;
  logic [TAG_W-1:0]         issue_dst_o;
  logic [CNT_W-1:0]         count_o;

  always #5 clk = ~clk;

  src_wakeup_buffer #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .NUM_WB(NUM_WB)) dut (
    .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_src1_i(alloc_src1_i), .alloc_src2_i(alloc_src2_i),
    .alloc_src1_ready_i(alloc_src1_ready_i), .alloc_src2_ready_i(alloc_src2_ready_i),
    .alloc_dst_i(alloc_dst_i), .wb_valid_i(wb_valid_i), .wb_tag_i(wb_tag_i), .wb_data_i(wb_data_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_src1_o(issue_src1_o), .issue_src2_o(issue_src2_o), .issue_dst_o(issue_dst_o),
    .count_o(count_o)
  );

  typedef struct {
    logic [DATA_W-1:0] s1;
    logic [DATA_W-1:0] s2;
    logic [TAG_W-1:0]  dst;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] s1, input logic [DATA_W-1:0] s2, input logic [TAG_W-1:0] dst);
    exp_t e;
    e.s1 = s1; e.s2 = s2; e.dst = dst;
    exp_q.push_back(e);
  endtask

  // One clock; an accepted issue is popped from the scoreboard and compared before the edge.
  task automatic cyc();
    exp_t e;
    if (issue_valid_o && issue_ready_i && !flush_i && !reset_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue", {58'd0, issue_dst_o}, 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_src1", 64'(issue_src1_o), 64'(e.s1));
        check("sb_src2", 64'(issue_src2_o), 64'(e.s2));
        check("sb_dst",  64'(issue_dst_o),  64'(e.dst));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [DATA_W-1:0] s1, input logic r1, input logic [DATA_W-1:0] s2,
                       input logic r2, input logic [TAG_W-1:0] dst);
    alloc_valid_i = 1'b1;
    alloc_src1_i = s1; alloc_src1_ready_i = r1;
    alloc_src2_i = s2; alloc_src2_ready_i = r2;
    alloc_dst_i = dst;
    cyc();
    alloc_valid_i = 1'b0;
  endtask

  task automatic bcast(input int k, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
    wb_valid_i[k] = 1'b1;
    wb_tag_i[k*TAG_W +: TAG_W] = tag;
    wb_data_i[k*DATA_W +: DATA_W] = data;
  endtask

  task automatic bclear();
    wb_valid_i = '0; wb_tag_i = '0; wb_data_i = '0;
  endtask

  // Accept everything queued; an expired budget counts as a failure.
  task automatic drain(input int budget);
    int n = 0;
    issue_ready_i = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      cyc();
      n++;
    end
    issue_ready_i = 1'b0;
    check("drain_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    cyc(); cyc();
    reset_i = 1'b0;
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_alloc_ready", 64'(alloc_ready_o), 64'd1);
    check("rst_issue_valid", 64'(issue_valid_o), 64'd0);
    check("rst_src1", 64'(issue_src1_o), 64'd0);
    check("rst_src2", 64'(issue_src2_o), 64'd0);
    check("rst_dst", 64'(issue_dst_o), 64'd0);

    // Basic ready-ready allocation
    alloc(32'h11, 1'b1, 32'h22, 1'b1, 6'd3);
    check("basic_valid", 64'(issue_valid_o), 64'd1);
    check("basic_src1", 64'(issue_src1_o), 64'h11);
    check("basic_src2", 64'(issue_src2_o), 64'h22);
    check("basic_dst", 64'(issue_dst_o), 64'd3);
    check("basic_count", 64'(count_o), 64'd1);
    push(32'h11, 32'h22, 6'd3);
    issue_ready_i = 1'b1;
    cyc();
    issue_ready_i = 1'b0;
    check("basic_count_after", 64'(count_o), 64'd0);
    check("basic_valid_after", 64'(issue_valid_o), 64'd0);

    // Two channels match one tag: lowest channel wins
    alloc(32'd5, 1'b0, 32'h33, 1'b1, 6'd1);
    check("wake_wait", 64'(issue_valid_o), 64'd0);
    bcast(1, 6'd5, 32'hAA);
    bcast(3, 6'd5, 32'hBB);
    cyc();
    bclear();
    check("wake_valid", 64'(issue_valid_o), 64'd1);
    check("wake_src1", 64'(issue_src1_o), 64'hAA);
    push(32'hAA, 32'h33, 6'd1);
    drain(10);

    // Invalid channels carrying tag 0 never wake a tag-0 operand
    alloc(32'h100, 1'b1, 32'd0, 1'b0, 6'd6);
    wb_data_i = {NUM_WB{32'hDEAD}};
    cyc(); cyc();
    check("tag0_idle", 64'(issue_valid_o), 64'd0);
    bclear();
    bcast(2, 6'd0, 32'h77);
    cyc();
    bclear();
    check("tag0_wake", 64'(issue_src2_o), 64'h77);
    push(32'h100, 32'h77, 6'd6);
    drain(10);

    // Full buffer ignores allocation even with a same-cycle issue
    for (int i = 0; i < DEPTH; i++) begin
      alloc(32'(i + 1), 1'b1, 32'(i + 16), 1'b1, 6'(10 + i));
      push(32'(i + 1), 32'(i + 16), 6'(10 + i));
    end
    check("full_count", 64'(count_o), 64'd4);
    check("full_ready", 64'(alloc_ready_o), 64'd0);
    issue_ready_i = 1'b1;
    alloc(32'h55, 1'b1, 32'h66, 1'b1, 6'd20);
    issue_ready_i = 1'b0;
    check("full_count_after", 64'(count_o), 64'd3);
    drain(10);
    check("full_drained", 64'(count_o), 64'd0);

    // Stall: entries 0 and 2 resolved, entry 1 waiting
    alloc(32'hA0, 1'b1, 32'hA1, 1'b1, 6'd30);
    alloc(32'd9, 1'b0, 32'hB1, 1'b1, 6'd31);
    alloc(32'hC0, 1'b1, 32'hC1, 1'b1, 6'd32);
    push(32'hA0, 32'hA1, 6'd30);
    push(32'hC0, 32'hC1, 6'd32);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_src1", 64'(issue_src1_o), 64'hA0);
      check("stall_dst", 64'(issue_dst_o), 64'd30);
    end
    issue_ready_i = 1'b1;
    cyc();
    check("stall_next_dst", 64'(issue_dst_o), 64'd32);
    cyc();
    issue_ready_i = 1'b0;
    bcast(4, 6'd9, 32'h99);
    cyc();
    bclear();
    push(32'h99, 32'hB1, 6'd31);
    drain(10);

    // A lower entry waking during a stall must not displace the presented entry
    alloc(32'hD0, 1'b1, 32'd4, 1'b0, 6'd40);
    alloc(32'hE0, 1'b1, 32'hE1, 1'b1, 6'd41);
    cyc();
    check("lock_dst", 64'(issue_dst_o), 64'd41);
    bcast(0, 6'd4, 32'h44);
    cyc();
    bclear();
    check("lock_dst_hold", 64'(issue_dst_o), 64'd41);
    check("lock_src1_hold", 64'(issue_src1_o), 64'hE0);
    push(32'hE0, 32'hE1, 6'd41);
    push(32'hD0, 32'h44, 6'd40);
    drain(10);

    // Flush beats allocation, wakeup and issue
    alloc(32'd8, 1'b0, 32'h1, 1'b1, 6'd50);
    alloc(32'h2, 1'b1, 32'h3, 1'b1, 6'd51);
    flush_i = 1'b1;
    issue_ready_i = 1'b1;
    bcast(0, 6'd8, 32'h88);
    alloc(32'h4, 1'b1, 32'h5, 1'b1, 6'd52);
    flush_i = 1'b0;
    issue_ready_i = 1'b0;
    bclear();
    check("flush_count", 64'(count_o), 64'd0);
    check("flush_valid", 64'(issue_valid_o), 64'd0);

    // Allocation-cycle broadcast
    bcast(0, 6'd7, 32'h5);
    alloc(32'h1, 1'b1, 32'd7, 1'b0, 6'd2);
    bclear();
`ifdef SRC_WAKEUP_ALLOC_BYPASS_EN
    check("bypass_valid", 64'(issue_valid_o), 64'd1);
    check("bypass_src2", 64'(issue_src2_o), 64'h5);
    push(32'h1, 32'h5, 6'd2);
    drain(10);
`else
    check("nobypass_valid", 64'(issue_valid_o), 64'd0);
    check("nobypass_count", 64'(count_o), 64'd1);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
`endif
    check("final_count", 64'(count_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/src_wakeup_buffer.md
SRC_WAKEUP_BUFFER -- requirements
Module: src_wakeup_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default `DATA_LEN, operand width.
REQ-002 SHALL have parameter TAG_W, default `RRF_SEL, rename-register tag width.
REQ-003 SHALL have parameter DEPTH, default 4, entry count (2..16).
REQ-004 SHALL have parameter NUM_WB, default 5, write-back broadcast channel count (1..8).
REQ-005 SHALL be synchronous to one clock with a synchronous active-high reset:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
REQ-006 SHALL have the following ports:
- flush_i  in  1  discard all entries.
- alloc_valid_i  in  1  allocation request.
- alloc_ready_o  out  1  free entry available.
- alloc_src1_i / alloc_src2_i  in  DATA_W each  operand value, or tag in [TAG_W-1:0].
- alloc_src1_ready_i / alloc_src2_ready_i  in  1 each  operand already holds a value.
- alloc_dst_i  in  TAG_W  destination tag payload.
- wb_valid_i  in  NUM_WB  broadcast valid per channel.
- wb_tag_i  in  NUM_WB*TAG_W  channel k at [k*TAG_W +: TAG_W].
- wb_data_i  in  NUM_WB*DATA_W  channel k at [k*DATA_W +: DATA_W].
- issue_valid_o  out  1  a fully resolved entry is presented.
- issue_ready_i  in  1  consumer accepts.
- issue_src1_o / issue_src2_o  out  DATA_W each  resolved operands.
- issue_dst_o  out  TAG_W  payload of the issued entry.
- count_o  out  $clog2(DEPTH+1)  occupied entries.

Function
REQ-007 Each entry SHALL hold valid, dst, and per operand {value, ready}; an entry is resolved when valid and both operands are ready.
REQ-008 An entry SHALL be written when alloc_valid_i & alloc_ready_o & !flush_i, into the lowest-index free entry.
REQ-009 alloc_ready_o SHALL be (count_o < DEPTH); it depends only on registered state, with no path from issue_ready_i.
REQ-010 Wakeup: for each valid entry operand with ready=0, on any channel k with wb_valid_i[k] and wb_tag_i[k] == operand[TAG_W-1:0], the operand value SHALL become wb_data_i[k] and ready SHALL be set at the next edge.
REQ-011 When several channels match one operand in the same cycle, the lowest k SHALL win.
REQ-012 Broadcasts with wb_valid_i[k]=0 SHALL never match, including tag 0.
REQ-013 issue_valid_o SHALL be 1 iff at least one entry is resolved; the outputs SHALL present the lowest-index resolved entry, driven from registered state only.
REQ-014 An entry SHALL be freed at the edge where issue_valid_o & issue_ready_i; outputs SHALL stay stable while issue_valid_o=1 and issue_ready_i=0, unless flush_i is asserted.
REQ-015 Latency:
- allocation with both operands ready at edge t: issuable in cycle t+1;
- wakeup captured at edge t: issuable in cycle t+1.
REQ-016 count_o SHALL equal the number of valid entries; a simultaneous allocate and issue in one cycle SHALL leave count_o unchanged.
REQ-017 When full (count_o=DEPTH), alloc_valid_i SHALL be ignored even if an issue occurs in the same cycle.
REQ-018 flush_i SHALL invalidate all entries at the next edge, take priority over allocation and wakeup, and consume no issue; count_o=0 and issue_valid_o=0 in the following cycle.
REQ-019 Alloc-cycle operand values already marked ready SHALL never be modified by broadcasts.

Reset
REQ-020 On reset_i=1 at an edge, all entries SHALL become invalid.
REQ-021 After reset: count_o=0, alloc_ready_o=1, issue_valid_o=0, and issue_src1_o, issue_src2_o and issue_dst_o all 0.
REQ-022 reset_i SHALL take priority over flush_i, allocation, wakeup and issue.

Configuration
REQ-023 Macro SRC_WAKEUP_ALLOC_BYPASS_EN:
- defined: an allocating operand with ready=0 SHALL also be compared against the same-cycle broadcasts (rules of REQ-010/011), and is stored as ready with the broadcast data.
- undefined: the operand is stored unready and upstream guarantees that no matching broadcast occurs in the allocation cycle.

Verification
REQ-024 After reset, allocate src1=0x11 (ready), src2=0x22 (ready), dst=3 -> next cycle issue_valid_o=1, issue_src1_o=0x11, issue_src2_o=0x22, issue_dst_o=3, count_o=1; with issue_ready_i=1 -> count_o=0.
REQ-025 Allocate src1 tag 5 (unready); one cycle later channels 1 and 3 both broadcast tag 5 with data 0xAA / 0xBB -> next cycle issue_src1_o=0xAA.
REQ-026 Fill DEPTH=4 entries, then hold alloc_valid_i=1 and issue_ready_i=1 for one cycle -> alloc_ready_o=0, the fifth request is not written, and count_o=3.
REQ-027 Stall: entries 0 and 2 resolved, issue_ready_i=0 for 3 cycles -> entry 0's data is held stable; then accept -> entry 2 is presented.
REQ-028 Flush with allocation and a broadcast in the same cycle -> next cycle count_o=0, issue_valid_o=0.
REQ-029 With the macro defined, allocate src2 tag 7 (unready) while channel 0 broadcasts tag 7 with data 0x5 -> next cycle issue_valid_o=1 and issue_src2_o=0x5; without the macro -> the entry is not issued.
